// File: rtl/isa_fetch.sv
// isa_fetch: fetches a run of ISA words from DRAM in bursts, buffers them in a
// small first-word-fall-through FIFO and streams them to the configuration
// control unit. A burst is requested only when the FIFO can absorb every beat
// it asks for, so the read-data port never has to stall for long.
module isa_fetch #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int NUMWORD_WIDTH   = 16,
    parameter int BURST_LEN       = 4,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       TOP_Start,
    input  logic [DRAM_ADDR_WIDTH-1:0] TOP_BaseAddr,
    input  logic [NUMWORD_WIDTH-1:0]   TOP_NumWord,
    output logic                       ISF_Busy,
    output logic                       ISF_Done,
    output logic                       ISF_RdReqVld,
    output logic [DRAM_ADDR_WIDTH-1:0] ISF_RdReqAddr,
    output logic [7:0]                 ISF_RdReqLen,
    input  logic                       DRM_RdReqRdy,
    input  logic [PORT_WIDTH-1:0]      DRM_RdDat,
    input  logic                       DRM_RdDatVld,
    output logic                       ISF_RdDatRdy,
    output logic [PORT_WIDTH-1:0]      ITFCCU_ISARdDat,
    output logic                       ITFCCU_ISARdDatVld,
    output logic                       ITFCCU_ISARdDatLast,
    input  logic                       CCUITF_ISARdDatRdy
);
    localparam int DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam int CNT_W      = FIFO_ADDR_WIDTH + 1;
    localparam int BEAT_BYTES = PORT_WIDTH / 8;

    typedef enum logic [1:0] { IDLE, REQ, DRAIN } state_t;

    state_t                     state, state_nxt;
    logic                       start_fetch, done_set, req_vld;
    logic                       req_hs, push, pop, fifo_full, fifo_vld, last_word;
    logic                       alive, done_q;
    logic [DRAM_ADDR_WIDTH-1:0] addr;
    logic [NUMWORD_WIDTH-1:0]   num_word, req_remain, delivered;
    logic [CNT_W-1:0]           fifo_count, outstanding;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [PORT_WIDTH-1:0]      mem [DEPTH];
    logic [7:0]                 len;
    logic [31:0]                free;

    // A full burst, or whatever is left of the fetch if that is shorter.
    assign len = (req_remain > NUMWORD_WIDTH'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(req_remain);

    // Slots not yet spoken for: neither holding a word nor reserved by an in-flight beat.
    // Pushes move a slot from reserved to held, pops only release slots, so once
    // free >= len it stays true until the request is accepted.
    assign free = 32'(DEPTH) - 32'(fifo_count) - 32'(outstanding);

    assign fifo_full   = (fifo_count == CNT_W'(DEPTH));
    assign fifo_vld    = (fifo_count != '0);
    assign req_hs      = req_vld & DRM_RdReqRdy;
    assign push        = DRM_RdDatVld & ISF_RdDatRdy;
    assign pop         = fifo_vld & CCUITF_ISARdDatRdy;
    assign last_word   = fifo_vld && (delivered == num_word - NUMWORD_WIDTH'(1));

    // 'alive' keeps the data-ready low while reset is held, even though the FIFO is empty.
    assign ISF_RdDatRdy        = alive & ~fifo_full;
    assign ISF_Busy            = (state != IDLE);
    assign ISF_Done            = done_q;
    assign ISF_RdReqVld        = req_vld;
    assign ISF_RdReqAddr       = addr;
    assign ISF_RdReqLen        = len;
    assign ITFCCU_ISARdDatVld  = fifo_vld;
    assign ITFCCU_ISARdDat     = fifo_vld ? mem[rd_ptr] : '0;
    assign ITFCCU_ISARdDatLast = last_word;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode, request valid, fetch start and completion strobes.
    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        done_set    = 1'b0;
        req_vld     = 1'b0;
        case (state)
            IDLE: begin
                if (TOP_Start) begin
                    if (TOP_NumWord != '0) begin
                        start_fetch = 1'b1;
                        state_nxt   = REQ;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            REQ: begin
                req_vld = (free >= 32'(len));
                if (req_vld && DRM_RdReqRdy && (req_remain == NUMWORD_WIDTH'(len)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && last_word) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch bookkeeping: request address, words left to request, words delivered, Done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive      <= 1'b0;
            done_q     <= 1'b0;
            addr       <= '0;
            num_word   <= '0;
            req_remain <= '0;
            delivered  <= '0;
        end else begin
            alive  <= 1'b1;
            done_q <= done_set;
            if (start_fetch) begin
                addr       <= TOP_BaseAddr;
                num_word   <= TOP_NumWord;
                req_remain <= TOP_NumWord;
                delivered  <= '0;
            end else begin
                if (req_hs) begin
                    addr       <= addr + DRAM_ADDR_WIDTH'(len) * DRAM_ADDR_WIDTH'(BEAT_BYTES);
                    req_remain <= req_remain - NUMWORD_WIDTH'(len);
                end
                if (pop) delivered <= delivered + NUMWORD_WIDTH'(1);
            end
        end
    end

    // Beats requested but not yet received; a same-cycle issue and arrival nets +len-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({req_hs, push})
                2'b10:   outstanding <= outstanding + CNT_W'(len);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                2'b11:   outstanding <= outstanding + CNT_W'(len) - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // FIFO occupancy and pointers; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= DRM_RdDat;
    end
endmodule
